// File: rtl/wb_regfile_stage.sv
// wb_regfile_stage: write-back stage with an integrated architectural register file.
// It selects the EX or MEM result, extends it, commits it, and counts retired
// instructions. An accepted ebreak parks the stage in HALT until halt_clear.
// Optional feature macro: WB_BYPASS_EN (same-cycle write-to-read bypass).
module wb_regfile_stage #(
   parameter int unsigned XLEN = 64,
   parameter int unsigned NREG = 32,
   parameter int unsigned AW   = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            in_wen,
   input  logic [AW-1:0]   in_waddr,
   input  logic [XLEN-1:0] in_ex_res,
   input  logic [XLEN-1:0] in_mem_res,
   input  logic            in_sel_mem,
   input  logic [2:0]      in_ext,
   input  logic            in_ebreak,
   input  logic [AW-1:0]   rs1_addr,
   input  logic [AW-1:0]   rs2_addr,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   output logic            retire,
   output logic [XLEN-1:0] instret,
   output logic            halted,
   input  logic            halt_clear
);

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_e;

   localparam logic [2:0] EXT_SEXT32 = 3'd1;
   localparam logic [2:0] EXT_ZEXT32 = 3'd2;
   localparam logic [2:0] EXT_SEXT16 = 3'd3;
   localparam logic [2:0] EXT_ZEXT16 = 3'd4;
   localparam logic [2:0] EXT_SEXT8  = 3'd5;
   localparam logic [2:0] EXT_ZEXT8  = 3'd6;

   state_e            state_q, state_d;
   logic              retire_q, retire_d;
   logic [XLEN-1:0]   instret_q, instret_d;
   logic [XLEN-1:0]   regs_q [NREG];
   logic [XLEN-1:0]   regs_d [NREG];

   logic              accept_c;
   logic              wr_c;
   logic [XLEN-1:0]   sel_c;
   logic [XLEN-1:0]   wdata_c;

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: ebreak accept parks the stage, halt_clear releases it
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:  if (accept_c && in_ebreak) state_d = ST_HALT;
         ST_HALT: if (halt_clear)            state_d = ST_RUN;
         default: state_d = ST_RUN;
      endcase
   end

   // FSM outputs: decoded directly from the state flop
   always_comb begin
      in_ready = 1'b0;
      halted   = 1'b0;
      case (state_q)
         ST_RUN:  in_ready = 1'b1;
         ST_HALT: halted   = 1'b1;
         default: in_ready = 1'b0;
      endcase
   end

   // Handshake and register-write qualification; x0 writes are dropped
   always_comb begin
      accept_c = in_valid && in_ready;
      wr_c     = accept_c && in_wen && (in_waddr != '0);
   end

   // Result select and width/sign extension of the write-back value
   always_comb begin
      sel_c = in_sel_mem ? in_mem_res : in_ex_res;
      case (in_ext)
         EXT_SEXT32: wdata_c = XLEN'($signed(sel_c[31:0]));
         EXT_ZEXT32: wdata_c = XLEN'(sel_c[31:0]);
         EXT_SEXT16: wdata_c = XLEN'($signed(sel_c[15:0]));
         EXT_ZEXT16: wdata_c = XLEN'(sel_c[15:0]);
         EXT_SEXT8:  wdata_c = XLEN'($signed(sel_c[7:0]));
         EXT_ZEXT8:  wdata_c = XLEN'(sel_c[7:0]);
         default:    wdata_c = sel_c;
      endcase
   end

   // Next register-file contents and retire bookkeeping
   always_comb begin
      regs_d = regs_q;
      if (wr_c) begin
         regs_d[in_waddr] = wdata_c;
      end
      retire_d  = accept_c;
      instret_d = accept_c ? instret_q + XLEN'(1) : instret_q;
   end

   // Datapath state: register file, retire pulse and retired-instruction counter
   always_ff @(posedge clk) begin
      if (rst) begin
         retire_q  <= 1'b0;
         instret_q <= '0;
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         retire_q  <= retire_d;
         instret_q <= instret_d;
         regs_q    <= regs_d;
      end
   end

   // Read port 1: x0 reads zero; optional bypass of the same-cycle write
   always_comb begin
      rs1_data = '0;
      if (rs1_addr != '0) begin
         rs1_data = regs_q[rs1_addr];
`ifdef WB_BYPASS_EN
         if (wr_c && (rs1_addr == in_waddr)) begin
            rs1_data = wdata_c;
         end
`else
`endif
      end
   end

   // Read port 2: same behaviour as port 1
   always_comb begin
      rs2_data = '0;
      if (rs2_addr != '0) begin
         rs2_data = regs_q[rs2_addr];
`ifdef WB_BYPASS_EN
         if (wr_c && (rs2_addr == in_waddr)) begin
            rs2_data = wdata_c;
         end
`else
`endif
      end
   end

   assign retire  = retire_q;
   assign instret = instret_q;

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Directed testbench for wb_regfile_stage (XLEN=64, NREG=32).
module tb_wb_regfile_stage;

   localparam int unsigned XLEN = 64;
   localparam int unsigned AW   = 5;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic            in_wen;
   logic [AW-1:0]   in_waddr;
   logic [XLEN-1:0] in_ex_res;
   logic [XLEN-1:0] in_mem_res;
   logic            in_sel_mem;
   logic [2:0]      in_ext;
   logic            in_ebreak;
   logic [AW-1:0]   rs1_addr;
   logic [AW-1:0]   rs2_addr;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic            retire;
   logic [XLEN-1:0] instret;
   logic            halted;
   logic            halt_clear;

   int errors = 0;
   int checks = 0;

   wb_regfile_stage #(.XLEN(XLEN), .NREG(32), .AW(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_wen     (in_wen),
      .in_waddr   (in_waddr),
      .in_ex_res  (in_ex_res),
      .in_mem_res (in_mem_res),
      .in_sel_mem (in_sel_mem),
      .in_ext     (in_ext),
      .in_ebreak  (in_ebreak),
      .rs1_addr   (rs1_addr),
      .rs2_addr   (rs2_addr),
      .rs1_data   (rs1_data),
      .rs2_data   (rs2_data),
      .retire     (retire),
      .instret    (instret),
      .halted     (halted),
      .halt_clear (halt_clear)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // advance past the next rising edge; samples land 2ns after it
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      in_valid   = 1'b0;
      in_wen     = 1'b0;
      in_ebreak  = 1'b0;
      halt_clear = 1'b0;
   endtask

   task automatic drive(input logic wen, input logic [AW-1:0] waddr, input logic [XLEN-1:0] ex,
                        input logic [XLEN-1:0] mem, input logic sel_mem, input logic [2:0] ext,
                        input logic ebreak);
      in_valid   = 1'b1;
      in_wen     = wen;
      in_waddr   = waddr;
      in_ex_res  = ex;
      in_mem_res = mem;
      in_sel_mem = sel_mem;
      in_ext     = ext;
      in_ebreak  = ebreak;
   endtask

   task automatic rd(input string tag, input logic [AW-1:0] addr, input logic [XLEN-1:0] exp);
      rs1_addr = addr;
      rs2_addr = addr;
      #1;
      chk({tag, "_rs1"}, rs1_data, exp);
      chk({tag, "_rs2"}, rs2_data, exp);
   endtask

   initial begin
      rst = 1'b1;
      idle();
      in_waddr = '0; in_ex_res = '0; in_mem_res = '0; in_sel_mem = 1'b0; in_ext = 3'd0;
      rs1_addr = '0; rs2_addr = '0;
      tick(); tick();
      rst = 1'b0;
      #1;

      // reset state, every register reads zero
      chk("rst_instret", instret, 64'd0);
      chk("rst_halted", XLEN'(halted), 64'd0);
      chk("rst_ready", XLEN'(in_ready), 64'd1);
      chk("rst_retire", XLEN'(retire), 64'd0);
      for (int r = 0; r < 32; r++) begin
         rd("rst_reg", AW'(r), 64'd0);
      end
      tick();

      // sext16 of a MEM result into x5
      drive(1'b1, 5'd5, 64'hDEAD, 64'h0000_0000_0000_8001, 1'b1, 3'd3, 1'b0);
      tick(); idle();
      chk("sext16_retire", XLEN'(retire), 64'd1);
      chk("sext16_instret", instret, 64'd1);
      rd("sext16_x5", 5'd5, 64'hFFFF_FFFF_FFFF_8001);
      tick();
      chk("sext16_retire_drop", XLEN'(retire), 64'd0);

      // zext16 of the same value
      drive(1'b1, 5'd5, 64'hDEAD, 64'h0000_0000_0000_8001, 1'b1, 3'd4, 1'b0);
      tick(); idle();
      chk("zext16_retire", XLEN'(retire), 64'd1);
      rd("zext16_x5", 5'd5, 64'h0000_0000_0000_8001);

      // back-to-back accepts exercising the remaining extension modes
      drive(1'b1, 5'd6, 64'h1234_5678_9ABC_DE80, 64'h0, 1'b0, 3'd5, 1'b0);
      tick();
      chk("sext8_retire", XLEN'(retire), 64'd1);
      rd("sext8_x6", 5'd6, 64'hFFFF_FFFF_FFFF_FF80);
      drive(1'b1, 5'd6, 64'h0000_0001_8000_0000, 64'h0, 1'b0, 3'd1, 1'b0);
      tick();
      chk("sext32_retire", XLEN'(retire), 64'd1);
      rd("sext32_x6", 5'd6, 64'hFFFF_FFFF_8000_0000);
      drive(1'b1, 5'd8, 64'hFFFF_FFFF_8000_0000, 64'h0, 1'b0, 3'd2, 1'b0);
      tick();
      rd("zext32_x8", 5'd8, 64'h0000_0000_8000_0000);
      drive(1'b1, 5'd10, 64'h0, 64'h0000_0000_0000_01FF, 1'b1, 3'd6, 1'b0);
      tick();
      rd("zext8_x10", 5'd10, 64'h0000_0000_0000_00FF);
      drive(1'b1, 5'd11, 64'hFFFF_0000_1234_5678, 64'h0, 1'b0, 3'd7, 1'b0);
      tick(); idle();
      rd("ext7_x11", 5'd11, 64'hFFFF_0000_1234_5678);
      chk("b2b_instret", instret, 64'd7);
      rd("x6_kept", 5'd6, 64'hFFFF_FFFF_8000_0000);

      // write to x0 is dropped but still retires
      drive(1'b1, 5'd0, 64'h1234, 64'h0, 1'b0, 3'd0, 1'b0);
      tick(); idle();
      rd("x0_zero", 5'd0, 64'd0);
      chk("x0_instret", instret, 64'd8);
      chk("x0_retire", XLEN'(retire), 64'd1);

      // same-cycle read of a register being written
      drive(1'b1, 5'd7, 64'h55, 64'h0, 1'b0, 3'd0, 1'b0);
      tick();
      drive(1'b1, 5'd7, 64'hAA, 64'h0, 1'b0, 3'd0, 1'b0);
      rs1_addr = 5'd7;
      #1;
`ifdef WB_BYPASS_EN
      chk("bypass_same_cycle", rs1_data, 64'hAA);
`else
      chk("nobypass_same_cycle", rs1_data, 64'h55);
`endif
      tick(); idle();
      rd("x7_next_cycle", 5'd7, 64'hAA);
      chk("x7_instret", instret, 64'd10);

      // two consecutive writes to the same register keep the second
      drive(1'b1, 5'd12, 64'h1, 64'h0, 1'b0, 3'd0, 1'b0);
      tick();
      drive(1'b1, 5'd12, 64'h2, 64'h0, 1'b0, 3'd0, 1'b0);
      tick(); idle();
      rd("x12_second", 5'd12, 64'h2);
      chk("x12_instret", instret, 64'd12);

      // ebreak with a write: completes, then parks the stage
      drive(1'b1, 5'd1, 64'h3, 64'h0, 1'b0, 3'd0, 1'b1);
      tick();
      chk("ebrk_halted", XLEN'(halted), 64'd1);
      chk("ebrk_ready", XLEN'(in_ready), 64'd0);
      chk("ebrk_retire", XLEN'(retire), 64'd1);
      chk("ebrk_instret", instret, 64'd13);
      rd("ebrk_x1", 5'd1, 64'h3);
      drive(1'b1, 5'd2, 64'h99, 64'h0, 1'b0, 3'd0, 1'b0);
      for (int c = 0; c < 4; c++) begin
         tick();
         chk("halt_ready", XLEN'(in_ready), 64'd0);
         chk("halt_instret", instret, 64'd13);
         chk("halt_retire", XLEN'(retire), 64'd0);
      end
      rd("halt_x2", 5'd2, 64'd0);

      // halt_clear with in_valid held: resume without accepting
      halt_clear = 1'b1;
      tick();
      halt_clear = 1'b0;
      in_valid   = 1'b0;
      #1;
      chk("clr_ready", XLEN'(in_ready), 64'd1);
      chk("clr_halted", XLEN'(halted), 64'd0);
      chk("clr_retire", XLEN'(retire), 64'd0);
      chk("clr_instret", instret, 64'd13);
      rd("clr_x2", 5'd2, 64'd0);
      idle();
      tick();

      // counter wrap from all-ones
      @(negedge clk);
      force dut.instret_q = '1;
      #1;
      release dut.instret_q;
      #1;
      chk("wrap_preload", instret, 64'hFFFF_FFFF_FFFF_FFFF);
      drive(1'b1, 5'd13, 64'h4242, 64'h0, 1'b0, 3'd0, 1'b0);
      tick(); idle();
      chk("wrap_instret", instret, 64'd0);
      chk("wrap_retire", XLEN'(retire), 64'd1);
      rd("wrap_x13", 5'd13, 64'h4242);

      // reset on an accept edge wins
      drive(1'b1, 5'd9, 64'h77, 64'h0, 1'b0, 3'd0, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      idle();
      #1;
      rd("rstacc_x9", 5'd9, 64'd0);
      rd("rstacc_x5", 5'd5, 64'd0);
      rd("rstacc_x7", 5'd7, 64'd0);
      chk("rstacc_instret", instret, 64'd0);
      chk("rstacc_retire", XLEN'(retire), 64'd0);
      chk("rstacc_halted", XLEN'(halted), 64'd0);
      chk("rstacc_ready", XLEN'(in_ready), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/wb_regfile_stage.md
# wb_regfile_stage

Parametrised write-back stage with integrated architectural register file for the NPC pipeline. It accepts one instruction per cycle from the MEM stage over a valid/ready handshake and selects the EX or MEM result. It applies width/sign extension and commits the value to the register file. It also keeps a retired-instruction counter and parks the pipeline in a HALT state on `ebreak` until released.

## Interface
Parameters:
- `XLEN`, 64, datapath and register width (32 or 64)
- `NREG`, 32, number of architectural registers; register 0 is hardwired to zero
- `AW`, 5, register address width; must equal clog2(`NREG`)

Ports:
- `clk`  in  1  clock; single clock domain, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  MEM stage presents an instruction
- `in_ready`  out  1  stage can accept this cycle
- `in_wen`  in  1  instruction writes a destination register
- `in_waddr`  in  AW  destination register
- `in_ex_res`  in  XLEN  EX-stage result
- `in_mem_res`  in  XLEN  MEM-stage (load) result
- `in_sel_mem`  in  1  1 selects `in_mem_res`, 0 selects `in_ex_res`
- `in_ext`  in  3  extension mode: 0 none, 1 sext32, 2 zext32, 3 sext16, 4 zext16, 5 sext8, 6 zext8, 7 reserved (treated as none)
- `in_ebreak`  in  1  instruction is `ebreak`
- `rs1_addr`, `rs2_addr`  in  AW  read-port addresses
- `rs1_data`, `rs2_data`  out  XLEN  read-port data, combinational
- `retire`  out  1  one-cycle pulse per committed instruction
- `instret`  out  XLEN  retired-instruction count
- `halted`  out  1  stage is in HALT
- `halt_clear`  in  1  releases HALT

## Operation
- FSM states: RUN, HALT. Reset state is RUN.
- `in_ready` = (state == RUN). Accept = `in_valid` && `in_ready`.
- `wdata` = ext(`in_sel_mem` ? `in_mem_res` : `in_ex_res`, `in_ext`). Extension takes the low 32/16/8 bits and sign- or zero-fills to XLEN. With XLEN=32, modes 1/2 equal none.
- On accept with `in_wen`=1 and `in_waddr`≠0, `regs[in_waddr]` <= `wdata`. A write to register 0 is dropped silently.
- On every accept, `instret` <= `instret`+1, wrapping modulo 2^XLEN, and `retire` is 1 in the next cycle. An accept with `in_wen`=0 still retires.
- On accept with `in_ebreak`=1, state <= HALT. That instruction's write and retire still complete.
- In HALT, `halt_clear`=1 sets state <= RUN. In RUN, `halt_clear` is ignored.
- Read ports: address 0 returns 0. Otherwise they return `regs[addr]`, subject to the bypass rule under Configuration.
- Reset: all `regs` = 0, `instret` = 0, `retire` = 0, `halted` = 0, `in_ready` = 1 in the first cycle after reset. Reset overrides any accept or `halt_clear` at the same edge.

## Timing
- Write latency: the value is architecturally visible from the cycle after the accept edge.
- `retire` is registered: it is high exactly the cycle after each accept and is never held for 2 cycles without 2 accepts.
- Back-to-back accepts are allowed every cycle in RUN. Two writes to the same register on consecutive cycles leave the second value.
- `halted` is high from the cycle after the `ebreak` accept. While `halted` is high, `in_ready`=0 and upstream must hold its inputs.
- HALT with `halt_clear` and `in_valid` in the same cycle: no accept that cycle. RUN resumes, and accepts are possible from the next cycle.
- `in_ext`/`in_sel_mem`/`in_waddr` are sampled only at accept; they are don't-care otherwise.

## Configuration
- `WB_BYPASS_EN` defined: a read whose address matches a same-cycle accepted write (`in_wen`=1, `in_waddr`≠0) returns `wdata` combinationally.
- `WB_BYPASS_EN` undefined: reads return the pre-write register contents in that cycle. The new value appears the next cycle, and no combinational path exists from the `in_*` data to `rs*_data`.

## Test plan
- Reset, then read all registers: every `rs*_data`=0, `instret`=0, `halted`=0, `in_ready`=1.
- Accept `in_wen`=1, `in_waddr`=5, `in_sel_mem`=1, `in_mem_res`=0x0000_0000_0000_8001, `in_ext`=3 (sext16). Required: next cycle x5 reads 0xFFFF_FFFF_FFFF_8001, and `retire`=1 for one cycle. Repeat with `in_ext`=4 (zext16) and require 0x8001.
- Write `in_waddr`=0 with 0x1234: x0 still reads 0, `instret` increments by 1.
- Accept a write of 0xAA to x7 while `rs1_addr`=7 in the same cycle. With `WB_BYPASS_EN`, `rs1_data`=0xAA that cycle. Without it, `rs1_data` is the old value, and 0xAA appears the next cycle.
- Accept an `ebreak` carrying a write of 3 to x1. Required: x1=3, `halted`=1, `in_ready`=0 with `in_valid` held high for 4 cycles and no `instret` change. Then pulse `halt_clear` and require `in_ready`=1 the next cycle.
- Preload `instret` to 2^XLEN−1 via forced accepts or a force, then accept once: `instret`=0. Assert `rst` on an accept edge: no write occurs and all outputs return to reset values.
